// File: rtl/trans_pkg.sv
// Shared definitions for the transaction feeder: transaction geometry, field
// offsets within a 128-bit transaction, and the output FSM state type.
package trans_pkg;
    localparam int TXN_W  = 128;
    localparam int BEAT_W = 32;
    localparam int BEATS  = 4;

    localparam int SENDER_MSB      = 127;
    localparam int SENDER_LSB      = 80;
    localparam int RECEIVER_MSB    = 79;
    localparam int RECEIVER_LSB    = 32;
    localparam int AMOUNT_MSB      = 31;
    localparam int AMOUNT_LSB      = 10;
    localparam int BLOCK_START_BIT = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLDOFF = 2'd2
    } feed_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead head output; simultaneous push and pop
// both take effect and leave the count unchanged.
module sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
endmodule

// File: rtl/trans_feeder.sv
// Assembles four 32-bit beats into a 128-bit transaction, queues it, and
// presents queued transactions one at a time on a valid/ack interface.
module trans_feeder
    import trans_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [127:0]                 data_o,
    output logic                         valid_o,
    input  logic                         ack_i,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count_o,
    output logic                         frame_err_o,
    output logic [CNT_W-1:0]             delivered_o
);
    localparam int          ASM_W     = TXN_W - BEAT_W;
    localparam logic [1:0]  LAST_BEAT = 2'(BEATS - 1);

    logic [1:0]        beat_cnt_q, beat_cnt_d;
    logic              frame_err_q, frame_err_d;
    logic [ASM_W-1:0]  asm_q;
    logic              beat_fire, at_last, push, pop;
    logic [TXN_W-1:0]  head;
    logic              fifo_full, fifo_empty;

    feed_state_t       state_q;
    logic              valid_q;
    logic [TXN_W-1:0]  data_q;
    logic [CNT_W-1:0]  delivered_q;

    // Only the final beat can stall: it needs a free slot, judged on registered occupancy.
    assign at_last   = (beat_cnt_q == LAST_BEAT);
    assign in_ready  = !(at_last && fifo_full);
    assign beat_fire = in_valid && in_ready;

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        if (beat_fire) begin
            if (in_last != at_last) begin
                beat_cnt_d  = '0;
                frame_err_d = 1'b1;
            end else if (at_last) begin
                beat_cnt_d = '0;
                push       = 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_fire && !at_last) asm_q <= {asm_q[ASM_W-BEAT_W-1:0], in_data};
    end

    sync_fifo #(
        .WIDTH (TXN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data ({asm_q, in_data}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count_o)
    );

    assign pop = (state_q == PRESENT) && ack_i;

    // HOLDOFF forces one low cycle of valid_o so an acked entry is never seen twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            data_q      <= '0;
            delivered_q <= '0;
        end else begin
            case (state_q)
                IDLE, HOLDOFF: begin
                    if (!fifo_empty) begin
                        state_q <= PRESENT;
                        valid_q <= 1'b1;
                        data_q  <= head;
                    end else begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                PRESENT: begin
                    if (ack_i) begin
                        state_q <= HOLDOFF;
                        valid_q <= 1'b0;
                        if (delivered_q != '1) delivered_q <= delivered_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign delivered_o = delivered_q;
endmodule

// File: tb/tb_trans_feeder.sv
// Scenario bench for trans_feeder: expected transactions are queued as they
// are driven and compared in order as the feeder presents them.
module tb_trans_feeder;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int CW    = $clog2(DEPTH+1);

    logic              clk;
    logic              rst_n;
    logic [31:0]       in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [127:0]      data_o;
    logic              valid_o;
    logic              ack_i;
    logic [CW-1:0]     fifo_count_o;
    logic              frame_err_o;
    logic [CNT_W-1:0]  delivered_o;

    int checks   = 0;
    int failures = 0;
    int exp_deliv = 0;
    logic [127:0] sb[$];

    trans_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ack_i        (ack_i),
        .fifo_count_o (fifo_count_o),
        .frame_err_o  (frame_err_o),
        .delivered_o  (delivered_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called 1 time unit after a rising edge; returns 1 unit after the accepting edge.
    task automatic send_beat(input logic [31:0] d, input logic l);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            failures++;
            $display("FAIL beat_accept_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_txn(input logic [127:0] t);
        sb.push_back(t);
        send_beat(t[127:96], 1'b0);
        send_beat(t[95:64],  1'b0);
        send_beat(t[63:32],  1'b0);
        send_beat(t[31:0],   1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b need 0", valid_o); end
        checks++; if (data_o !== 128'h0) begin failures++; $display("FAIL rst_data: got %h need 0", data_o); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %0b need 1", in_ready); end
        checks++; if (fifo_count_o !== '0) begin failures++; $display("FAIL rst_count: got %0d need 0", fifo_count_o); end
        checks++; if (frame_err_o !== 1'b0) begin failures++; $display("FAIL rst_ferr: got %0b need 0", frame_err_o); end
        checks++; if (delivered_o !== '0) begin failures++; $display("FAIL rst_deliv: got %0d need 0", delivered_o); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_first_txn();
        send_txn(128'h11111111_22222222_33333333_44444444);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL lat_t1_valid: got %0b need 0", valid_o); end
        checks++; if (fifo_count_o !== CW'(1)) begin failures++; $display("FAIL lat_t1_count: got %0d need 1", fifo_count_o); end
        @(posedge clk); #1;
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL lat_t2_valid: got %0b need 1", valid_o); end
        checks++; if (data_o !== 128'h11111111_22222222_33333333_44444444) begin
            failures++; $display("FAIL first_data: got %h need 11111111222222223333333344444444", data_o);
        end
    endtask

    task automatic test_hold_ack();
        logic [127:0] exp;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if (valid_o !== 1'b1 || data_o !== sb[0]) begin
                failures++; $display("FAIL hold_stable: valid=%0b data=%h need 1 %h", valid_o, data_o, sb[0]);
            end
        end
        exp = sb.pop_front();
        checks++; if (data_o !== exp) begin failures++; $display("FAIL hold_sb: got %h need %h", data_o, exp); end
        ack_i = 1'b1;
        @(posedge clk); #1;
        ack_i = 1'b0;
        exp_deliv++;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL ack_holdoff: got %0b need 0", valid_o); end
        checks++; if (fifo_count_o !== '0) begin failures++; $display("FAIL ack_count: got %0d need 0", fifo_count_o); end
        checks++; if (delivered_o !== CNT_W'(exp_deliv)) begin failures++; $display("FAIL ack_deliv: got %0d need %0d", delivered_o, exp_deliv); end
        @(posedge clk); #1;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL idle_after: got %0b need 0", valid_o); end
    endtask

    task automatic test_full();
        logic [127:0] exp, t9;
        for (int i = 0; i < DEPTH; i++) send_txn({4{8'hA0 + 8'(i), 24'(i * 3 + 1)}});
        checks++; if (fifo_count_o !== CW'(DEPTH)) begin failures++; $display("FAIL full_count: got %0d need %0d", fifo_count_o, DEPTH); end
        t9 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        sb.push_back(t9);
        send_beat(t9[127:96], 1'b0);
        send_beat(t9[95:64],  1'b0);
        send_beat(t9[63:32],  1'b0);
        in_data = t9[31:0]; in_valid = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_stall: got %0b need 0", in_ready); end
            @(posedge clk); #1;
        end
        checks++; if (fifo_count_o !== CW'(DEPTH)) begin failures++; $display("FAIL full_hold: got %0d need %0d", fifo_count_o, DEPTH); end
        exp = sb.pop_front();
        checks++; if (data_o !== exp) begin failures++; $display("FAIL full_sb: got %h need %h", data_o, exp); end
        ack_i = 1'b1;
        @(posedge clk); #1;
        ack_i = 1'b0;
        exp_deliv++;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_pop_ready: got %0b need 1", in_ready); end
        checks++; if (fifo_count_o !== CW'(DEPTH-1)) begin failures++; $display("FAIL post_pop_count: got %0d need %0d", fifo_count_o, DEPTH-1); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (fifo_count_o !== CW'(DEPTH)) begin failures++; $display("FAIL refill_count: got %0d need %0d", fifo_count_o, DEPTH); end
        for (int k = 0; k < 400 && sb.size() > 0; k++) begin
            if (valid_o) begin
                exp = sb.pop_front();
                checks++; if (data_o !== exp) begin failures++; $display("FAIL full_drain: got %h need %h", data_o, exp); end
                ack_i = 1'b1; @(posedge clk); #1; ack_i = 1'b0;
                exp_deliv++;
                checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL full_holdoff: got %0b need 0", valid_o); end
            end else begin
                @(posedge clk); #1;
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL full_drain_timeout: left %0d need 0", sb.size()); end
        checks++; if (delivered_o !== CNT_W'(exp_deliv)) begin failures++; $display("FAIL full_deliv: got %0d need %0d", delivered_o, exp_deliv); end
    endtask

    task automatic test_framing();
        logic [127:0] exp;
        send_beat(32'hBAD00000, 1'b0);
        send_beat(32'hBAD00001, 1'b0);
        send_beat(32'hBAD00002, 1'b1);
        checks++; if (frame_err_o !== 1'b1) begin failures++; $display("FAIL ferr_early: got %0b need 1", frame_err_o); end
        @(posedge clk); #1;
        checks++; if (frame_err_o !== 1'b0) begin failures++; $display("FAIL ferr_pulse: got %0b need 0", frame_err_o); end
        send_txn(128'h0000AAAA_1111BBBB_2222CCCC_3333DDDD);
        checks++; if (frame_err_o !== 1'b0) begin failures++; $display("FAIL ferr_clean: got %0b need 0", frame_err_o); end
        send_beat(32'hBAD10000, 1'b0);
        send_beat(32'hBAD10001, 1'b0);
        send_beat(32'hBAD10002, 1'b0);
        send_beat(32'hBAD10003, 1'b0);
        checks++; if (frame_err_o !== 1'b1) begin failures++; $display("FAIL ferr_nolast: got %0b need 1", frame_err_o); end
        checks++; if (fifo_count_o !== CW'(1)) begin failures++; $display("FAIL ferr_count: got %0d need 1", fifo_count_o); end
        for (int k = 0; k < 100 && sb.size() > 0; k++) begin
            if (valid_o) begin
                exp = sb.pop_front();
                checks++; if (data_o !== exp) begin failures++; $display("FAIL ferr_drain: got %h need %h", data_o, exp); end
                ack_i = 1'b1; @(posedge clk); #1; ack_i = 1'b0;
                exp_deliv++;
            end else begin
                @(posedge clk); #1;
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL ferr_drain_timeout: left %0d need 0", sb.size()); end
        repeat (2) @(posedge clk); #1;
        checks++; if (valid_o !== 1'b0 || fifo_count_o !== '0) begin
            failures++; $display("FAIL ferr_only_clean: valid=%0b count=%0d need 0 0", valid_o, fifo_count_o);
        end
    endtask

    task automatic test_push_pop_same();
        logic [127:0] exp, td;
        send_txn(128'hA0000000_A0000001_A0000002_A0000003);
        send_txn(128'hB0000000_B0000001_B0000002_B0000003);
        send_txn(128'hC0000000_C0000001_C0000002_C0000003);
        checks++; if (fifo_count_o !== CW'(3)) begin failures++; $display("FAIL pp_pre_count: got %0d need 3", fifo_count_o); end
        td = 128'hD0000000_D0000001_D0000002_D0000003;
        sb.push_back(td);
        send_beat(td[127:96], 1'b0);
        send_beat(td[95:64],  1'b0);
        send_beat(td[63:32],  1'b0);
        exp = sb.pop_front();
        checks++; if (valid_o !== 1'b1 || data_o !== exp) begin
            failures++; $display("FAIL pp_head: valid=%0b data=%h need 1 %h", valid_o, data_o, exp);
        end
        in_data = td[31:0]; in_valid = 1'b1; in_last = 1'b1; ack_i = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; ack_i = 1'b0;
        exp_deliv++;
        checks++; if (fifo_count_o !== CW'(3)) begin failures++; $display("FAIL pp_count: got %0d need 3", fifo_count_o); end
        for (int k = 0; k < 100 && sb.size() > 0; k++) begin
            if (valid_o) begin
                exp = sb.pop_front();
                checks++; if (data_o !== exp) begin failures++; $display("FAIL pp_order: got %h need %h", data_o, exp); end
                ack_i = 1'b1; @(posedge clk); #1; ack_i = 1'b0;
                exp_deliv++;
            end else begin
                @(posedge clk); #1;
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL pp_drain_timeout: left %0d need 0", sb.size()); end
        repeat (2) @(posedge clk); #1;
        ack_i = 1'b1; @(posedge clk); #1; ack_i = 1'b0;
        @(posedge clk); #1;
        checks++; if (delivered_o !== CNT_W'(exp_deliv)) begin failures++; $display("FAIL spurious_deliv: got %0d need %0d", delivered_o, exp_deliv); end
        checks++; if (valid_o !== 1'b0 || fifo_count_o !== '0) begin
            failures++; $display("FAIL spurious_state: valid=%0b count=%0d need 0 0", valid_o, fifo_count_o);
        end
    endtask

    task automatic test_async_reset();
        logic [127:0] exp;
        for (int i = 0; i < 5; i++) send_txn({4{32'h5E000000 + 32'(i)}});
        send_beat(32'h77777777, 1'b0);
        send_beat(32'h88888888, 1'b0);
        checks++; if (valid_o !== 1'b1 || fifo_count_o !== CW'(5)) begin
            failures++; $display("FAIL ar_pre: valid=%0b count=%0d need 1 5", valid_o, fifo_count_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL ar_valid: got %0b need 0", valid_o); end
        checks++; if (fifo_count_o !== '0) begin failures++; $display("FAIL ar_count: got %0d need 0", fifo_count_o); end
        checks++; if (delivered_o !== '0) begin failures++; $display("FAIL ar_deliv: got %0d need 0", delivered_o); end
        sb.delete();
        exp_deliv = 0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send_txn(128'h12345678_9ABCDEF0_0FEDCBA9_87654321);
        for (int k = 0; k < 20 && !valid_o; k++) begin @(posedge clk); #1; end
        exp = sb.pop_front();
        checks++; if (valid_o !== 1'b1 || data_o !== exp) begin
            failures++; $display("FAIL ar_after: valid=%0b data=%h need 1 %h", valid_o, data_o, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; ack_i = 1'b0;
        test_reset();
        test_first_txn();
        test_hold_ack();
        test_full();
        test_framing();
        test_push_pop_same();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
